// File: rtl/dma_rd_req.sv
// dma_rd_req: splits a read command (64 B aligned start, N beats) into AXI
// read bursts of at most 16 beats that never cross a 4 KB page, limits the
// number of bursts in flight, and forwards returning beats to a consumer.
//
// Ports:
//   clk, reset                      clock, synchronous active-low reset
//   cmd_addr/beats/id/valid/ready   command input (beats == 0 is illegal)
//   araddr/arid/arlen/arvalid/arready   AXI read address channel
//   rdata/rid/rlast/rvalid/rready       AXI read data channel
//   dout_data/last/valid/ready      zero-latency beat stream to the consumer
//   done                            one-cycle pulse when a command completes
//   err                             sticky error (zero-beat cmd, bad rid, stray beat)
module dma_rd_req #(
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [63:0]  cmd_addr,
    input  logic [15:0]  cmd_beats,
    input  logic [7:0]   cmd_id,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    output logic [63:0]  araddr,
    output logic [7:0]   arid,
    output logic [3:0]   arlen,
    output logic         arvalid,
    input  logic         arready,
    input  logic [511:0] rdata,
    input  logic [7:0]   rid,
    input  logic         rlast,
    input  logic         rvalid,
    output logic         rready,
    output logic [511:0] dout_data,
    output logic         dout_last,
    output logic         dout_valid,
    input  logic         dout_ready,
    output logic         done,
    output logic         err
);

    localparam int unsigned OUT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [63:0]      addr_q, addr_d;
    logic [15:0]      rem_q, rem_d;
    logic [7:0]       id_q, id_d;
    logic [OUT_W-1:0] outst_q, outst_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [6:0]       page_left;
    logic [4:0]       nb;
    logic             ar_fire;
    logic             r_beat;
    logic             r_cmpl;

    // Burst size: remaining beats, capped at 16 and at the end of the 4 KB page
    always_comb begin
        page_left = 7'd64 - {1'b0, addr_q[11:6]};
        nb        = 5'd16;
        if ({2'b00, nb} > page_left) nb = page_left[4:0];
        if ({11'd0, nb} > rem_q)     nb = rem_q[4:0];
    end

    // AR channel driven straight from the latched command; outstanding can only
    // fall while arvalid waits, so arvalid and its payload hold until accepted
    assign arvalid   = (state_q == ISSUE) && ({28'd0, outst_q} < 32'(MAX_OUTSTANDING));
    assign araddr    = addr_q;
    assign arid      = id_q;
    assign arlen     = 4'(nb - 5'd1);
    assign cmd_ready = (state_q == IDLE) && reset;

    // R channel pass-through
    assign rready     = dout_ready;
    assign dout_valid = rvalid;
    assign dout_data  = rdata;
    assign dout_last  = rvalid && rlast && (state_q == DRAIN) && (outst_q == OUT_W'(1));

    assign ar_fire = arvalid && arready;
    assign r_beat  = rvalid && dout_ready;
    // A completing rlast only counts against a burst that is actually in flight
    assign r_cmpl  = r_beat && rlast && (outst_q != '0);

    assign done = done_q;
    assign err  = err_q;

    // Next-state and datapath updates
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        id_d    = id_q;
        outst_d = outst_q;
        done_d  = 1'b0;
        err_d   = err_q;

        if (ar_fire && !r_cmpl)      outst_d = outst_q + OUT_W'(1);
        else if (!ar_fire && r_cmpl) outst_d = outst_q - OUT_W'(1);

        if (r_beat && (outst_q == '0))                err_d = 1'b1;
        if (r_beat && (state_q != IDLE) && (rid != id_q)) err_d = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_beats == '0) begin
                        err_d = 1'b1;
                    end else begin
                        addr_d  = cmd_addr & ~64'h3F;
                        rem_d   = cmd_beats;
                        id_d    = cmd_id;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (ar_fire) begin
                    addr_d = addr_q + {53'd0, nb, 6'd0};
                    rem_d  = rem_q - {11'd0, nb};
                    if (rem_q == {11'd0, nb}) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (r_cmpl && (outst_q == OUT_W'(1))) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            id_q    <= '0;
            outst_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            id_q    <= id_d;
            outst_q <= outst_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

endmodule
